// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg -- runtime-configurable UART transmitter with a transmit FIFO.
//
// Frame format is chosen per frame and sampled when the frame is popped:
// start bit, 5..DATA_WIDTH data bits (LSB first), optional even/odd parity,
// then 1 or 2 stop bits. Every bit lasts baud_div_i clock cycles.
//
// Ports:
//   clk_i, rst_ni   system clock, asynchronous active-low reset
//   baud_div_i      clocks per bit (0 behaves as 1)
//   data_len_i      data bits per frame, clamped to 5..DATA_WIDTH
//   parity_en_i     append a parity bit
//   parity_odd_i    1 = odd parity, 0 = even parity
//   stop2_i         1 = two stop bits
//   tx_we_i, din_i  FIFO write strobe and data
//   tx_en_i         allow new frames to start
//   tx_bit_o        serial line, idles high, driven from a flop
//   empty_o, full_o, count_o   registered FIFO status
//   busy_o          a frame is on the line
//   done_o          one-cycle pulse on the last cycle of a frame
//   overflow_o      sticky; a write was dropped because the FIFO was full
module uart_tx_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int BAUD_W     = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [BAUD_W-1:0]             baud_div_i,
  input  logic [3:0]                    data_len_i,
  input  logic                          parity_en_i,
  input  logic                          parity_odd_i,
  input  logic                          stop2_i,
  input  logic                          tx_we_i,
  input  logic [DATA_WIDTH-1:0]         din_i,
  input  logic                          tx_en_i,
  output logic                          tx_bit_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [3:0] MIN_LEN = 4'd5;
  localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  // ---------------------------------------------------------------- FIFO
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, full_q, overflow_q;
  logic                  push, pop;
  logic [DATA_WIDTH-1:0] head;

  assign head = mem[rd_ptr_q];
  // A pop frees the slot in the same cycle, so a write at full still lands.
  assign push = tx_we_i && (!full_q || pop);

  always_comb begin
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == CW'(FIFO_DEPTH));
      if (tx_we_i && !push) overflow_q <= 1'b1;
    end
  end

  // NOTE: the storage array has no reset; resetting the pointers already
  // discards its contents, and a reset here would defeat RAM inference.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q] <= din_i;
  end

  // ------------------------------------------------ per-frame config decode
  logic [3:0]        len_c;
  logic [BAUD_W-1:0] b_m1_c;
  logic              par_c;

  // NOTE: every variable assigned in always_comb gets a value on every path
  // (defaults first); a missed path would infer a latch.
  always_comb begin
    if (data_len_i < MIN_LEN)      len_c = MIN_LEN;
    else if (data_len_i > MAX_LEN) len_c = MAX_LEN;
    else                           len_c = data_len_i;
    b_m1_c = (baud_div_i == '0) ? '0 : baud_div_i - BAUD_W'(1);
    // Parity covers only the bits that will actually be sent.
    par_c = parity_odd_i;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (i < int'(len_c)) par_c = par_c ^ head[i];
    end
  end

  // ---------------------------------------------------------------- FSM
  state_e                state_q, state_d;
  logic [BAUD_W-1:0]     cnt_q, cnt_d, b_m1_q;
  logic [3:0]            len_q, bits_q, bits_d;
  logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic                  par_en_q, par_bit_q, stop2_q;
  logic                  stop_second_q, stop_second_d;
  logic                  tx_q, tx_d;
  logic                  tick, can_start, last_stop;

  assign tick      = (cnt_q == '0);
  assign can_start = tx_en_i && !empty_q;
  assign last_stop = (state_q == STOP) && tick && (!stop2_q || stop_second_q);

  // tx_d is the line value for the cycle after the edge, so the line itself
  // comes straight off tx_q.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bits_d        = bits_q;
    shreg_d       = shreg_q;
    stop_second_d = stop_second_q;
    tx_d          = tx_q;
    pop           = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (can_start) begin
          pop     = 1'b1;
          state_d = START;
          cnt_d   = b_m1_c;
          shreg_d = head;
          tx_d    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          cnt_d   = b_m1_q;
          bits_d  = len_q - 4'd1;
          tx_d    = shreg_q[0];
        end else cnt_d = cnt_q - BAUD_W'(1);
      end
      DATA: begin
        if (tick) begin
          cnt_d = b_m1_q;
          if (bits_q == '0) begin
            if (par_en_q) begin
              state_d = PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d       = STOP;
              stop_second_d = 1'b0;
              tx_d          = 1'b1;
            end
          end else begin
            bits_d  = bits_q - 4'd1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end else cnt_d = cnt_q - BAUD_W'(1);
      end
      PARITY: begin
        if (tick) begin
          state_d       = STOP;
          cnt_d         = b_m1_q;
          stop_second_d = 1'b0;
          tx_d          = 1'b1;
        end else cnt_d = cnt_q - BAUD_W'(1);
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - BAUD_W'(1);
        end else if (!last_stop) begin
          stop_second_d = 1'b1;
          cnt_d         = b_m1_q;
        end else if (can_start) begin
          // Back-to-back: the next start bit follows the stop bit directly.
          pop     = 1'b1;
          state_d = START;
          cnt_d   = b_m1_c;
          shreg_d = head;
          tx_d    = 1'b0;
        end else begin
          state_d = IDLE;
          tx_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      bits_q        <= '0;
      shreg_q       <= '0;
      stop_second_q <= 1'b0;
      tx_q          <= 1'b1;
      b_m1_q        <= '0;
      len_q         <= MIN_LEN;
      par_en_q      <= 1'b0;
      par_bit_q     <= 1'b0;
      stop2_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bits_q        <= bits_d;
      shreg_q       <= shreg_d;
      stop_second_q <= stop_second_d;
      tx_q          <= tx_d;
      // Configuration is captured only as a frame is popped.
      if (pop) begin
        b_m1_q    <= b_m1_c;
        len_q     <= len_c;
        par_en_q  <= parity_en_i;
        par_bit_q <= par_c;
        stop2_q   <= stop2_i;
      end
    end
  end

  assign tx_bit_o   = tx_q;
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign count_o    = count_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = last_stop;
  assign overflow_o = overflow_q;

endmodule
